// File: rtl/shreg_pkg.sv
// rtl/shreg_pkg.sv - mode encodings, per-bit select codes and shift-op decode for shift_reg_u
package shreg_pkg;

    localparam logic [2:0] MODE_HOLD = 3'd0;
    localparam logic [2:0] MODE_LOAD = 3'd1;
    localparam logic [2:0] MODE_SHL  = 3'd2;
    localparam logic [2:0] MODE_SHR  = 3'd3;
    localparam logic [2:0] MODE_ASR  = 3'd4;
    localparam logic [2:0] MODE_ROL  = 3'd5;
    localparam logic [2:0] MODE_ROR  = 3'd6;
    localparam logic [2:0] MODE_RSVD = 3'd7;

    // Per-bit next-value source: lo = neighbour at index i-1, hi = neighbour at index i+1
    typedef enum logic [1:0] {
        CELL_HOLD = 2'd0,
        CELL_LOAD = 2'd1,
        CELL_LO   = 2'd2,
        CELL_HI   = 2'd3
    } cell_sel_t;

    function automatic logic is_shift_mode(input logic [2:0] m);
        return (m >= MODE_SHL) && (m <= MODE_ROR);
    endfunction

endpackage

// File: rtl/shreg_cell.sv
// rtl/shreg_cell.sv - one storage bit: next-value mux plus flop with synchronous reset and clear
module shreg_cell
    import shreg_pkg::*;
(
    input  logic      clk,
    input  logic      rst_b,
    input  logic      clr,
    input  cell_sel_t sel,
    input  logic      load_val,
    input  logic      lo_val,
    input  logic      hi_val,
    output logic      q
);

    always_ff @(posedge clk) begin
        if (rst_b) begin
            q <= 1'b0;
        end else if (clr) begin
            q <= 1'b0;
        end else begin
            case (sel)
                CELL_LOAD: q <= load_val;
                CELL_LO:   q <= lo_val;
                CELL_HI:   q <= hi_val;
                default:   q <= q;
            endcase
        end
    end

endmodule

// File: rtl/shift_reg_u.sv
// rtl/shift_reg_u.sv - universal shift/rotate register; optional shift counter when SHREG_CNT_EN is defined
module shift_reg_u
    import shreg_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             en,
    input  logic             clr,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] din,
    input  logic             sin,
    input  logic             cnt_ld,
    input  logic [CNT_W-1:0] cnt_init,
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic [CNT_W-1:0] cnt,
    output logic             done
);

    cell_sel_t sel;
    logic      lo_edge;
    logic      hi_edge;

    always_comb begin
        sel = CELL_HOLD;
        if (en) begin
            case (mode)
                MODE_LOAD:                     sel = CELL_LOAD;
                MODE_SHL, MODE_ROL:            sel = CELL_LO;
                MODE_SHR, MODE_ASR, MODE_ROR:  sel = CELL_HI;
                default:                       sel = CELL_HOLD;
            endcase
        end
    end

    // Bits shifted into the two ends: serial input, sign copy or wrap-around
    always_comb begin
        lo_edge = (mode == MODE_ROL) ? q[WIDTH-1] : sin;
        case (mode)
            MODE_ASR: hi_edge = q[WIDTH-1];
            MODE_ROR: hi_edge = q[0];
            default:  hi_edge = sin;
        endcase
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        shreg_cell u_cell (
            .clk      (clk),
            .rst_b    (rst_b),
            .clr      (clr),
            .sel      (sel),
            .load_val (din[i]),
            .lo_val   ((i == 0) ? lo_edge : q[(i == 0) ? 0 : i-1]),
            .hi_val   ((i == WIDTH-1) ? hi_edge : q[(i == WIDTH-1) ? WIDTH-1 : i+1]),
            .q        (q[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst_b) begin
            sout <= 1'b0;
        end else if (clr) begin
            sout <= 1'b0;
        end else if (en) begin
            case (mode)
                MODE_LOAD:                     sout <= 1'b0;
                MODE_SHL, MODE_ROL:            sout <= q[WIDTH-1];
                MODE_SHR, MODE_ASR, MODE_ROR:  sout <= q[0];
                default:                       sout <= sout;
            endcase
        end
    end

`ifdef SHREG_CNT_EN
    logic shift_op;
    assign shift_op = en && is_shift_mode(mode) && !clr;

    // A preload on the final-shift edge wins and swallows the done pulse
    always_ff @(posedge clk) begin
        if (rst_b) begin
            cnt  <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (cnt_ld) begin
                cnt <= cnt_init;
            end else if (shift_op && (cnt != '0)) begin
                cnt <= cnt - CNT_W'(1);
                done <= (cnt == CNT_W'(1));
            end
        end
    end
`else
    logic unused_cnt_in;
    assign unused_cnt_in = ^{cnt_ld, cnt_init};
    assign cnt  = '0;
    assign done = 1'b0;
`endif

endmodule

// File: tb/tb_shift_reg_u.sv
// tb/tb_shift_reg_u.sv - scoreboard bench for shift_reg_u with directed vectors
module tb_shift_reg_u;

`ifdef SHREG_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_b = 1'b1;
    logic       en = 1'b0;
    logic       clr = 1'b0;
    logic [2:0] mode = 3'd0;
    logic [7:0] din = 8'h00;
    logic       sin = 1'b0;
    logic       cnt_ld = 1'b0;
    logic [3:0] cnt_init = 4'd0;
    logic [7:0] q;
    logic       sout;
    logic [3:0] cnt;
    logic       done;

    shift_reg_u #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst_b    (rst_b),
        .en       (en),
        .clr      (clr),
        .mode     (mode),
        .din      (din),
        .sin      (sin),
        .cnt_ld   (cnt_ld),
        .cnt_init (cnt_init),
        .q        (q),
        .sout     (sout),
        .cnt      (cnt),
        .done     (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [7:0] q;
        logic       s;
        logic [3:0] c;
        logic       d;
    } exp_t;

    exp_t exp_q[$];
    int   passed = 0;
    int   total = 0;

    function automatic logic [3:0] ec(input logic [3:0] v);
        return CNT_ON ? v : 4'd0;
    endfunction

    function automatic logic ed(input logic v);
        return CNT_ON ? v : 1'b0;
    endfunction

    task automatic step(input string name, input logic r, input logic e, input logic c,
                        input logic [2:0] m, input logic [7:0] d, input logic s,
                        input logic ld, input logic [3:0] init,
                        input logic [7:0] eq, input logic es, input logic [3:0] ecn,
                        input logic edn);
        exp_t x;
        @(negedge clk);
        rst_b = r; en = e; clr = c; mode = m; din = d; sin = s;
        cnt_ld = ld; cnt_init = init;
        x.name = name; x.q = eq; x.s = es; x.c = ec(ecn); x.d = ed(edn);
        exp_q.push_back(x);
    endtask

    task automatic chk(input string name, input string field, input logic [7:0] act,
                       input logic [7:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s.%s: got %0h expected %0h", name, field, act, req);
    endtask

    // Monitor: every edge after a command has been issued presents a result to compare
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                chk(x.name, "q", q, x.q);
                chk(x.name, "sout", {7'd0, sout}, {7'd0, x.s});
                chk(x.name, "cnt", {4'd0, cnt}, {4'd0, x.c});
                chk(x.name, "done", {7'd0, done}, {7'd0, x.d});
            end
        end
    end

    initial begin
        //    name          rst en clr mode din    sin ld init   q      sout cnt done
        step("reset0",      1, 1, 0, 3'd1, 8'hFF, 0, 0, 4'd0, 8'h00, 0, 4'd0, 0);
        step("reset1",      1, 1, 0, 3'd1, 8'hFF, 0, 0, 4'd0, 8'h00, 0, 4'd0, 0);
        step("load_b5",     0, 1, 0, 3'd1, 8'hB5, 0, 0, 4'd0, 8'hB5, 0, 4'd0, 0);
        step("shl_sin1",    0, 1, 0, 3'd2, 8'h00, 1, 0, 4'd0, 8'h6B, 1, 4'd0, 0);
        step("shr_sin0",    0, 1, 0, 3'd3, 8'h00, 0, 0, 4'd0, 8'h35, 1, 4'd0, 0);
        step("load_96",     0, 1, 0, 3'd1, 8'h96, 0, 0, 4'd0, 8'h96, 0, 4'd0, 0);
        step("asr",         0, 1, 0, 3'd4, 8'h00, 1, 0, 4'd0, 8'hCB, 0, 4'd0, 0);
        step("ror",         0, 1, 0, 3'd6, 8'h00, 0, 0, 4'd0, 8'hE5, 1, 4'd0, 0);
        step("rol",         0, 1, 0, 3'd5, 8'h00, 0, 0, 4'd0, 8'hCB, 1, 4'd0, 0);
        step("ld_cnt3",     0, 1, 0, 3'd1, 8'h01, 0, 1, 4'd3, 8'h01, 0, 4'd3, 0);
        step("cnt_shl1",    0, 1, 0, 3'd2, 8'h00, 0, 0, 4'd0, 8'h02, 0, 4'd2, 0);
        step("cnt_shl2",    0, 1, 0, 3'd2, 8'h00, 0, 0, 4'd0, 8'h04, 0, 4'd1, 0);
        step("cnt_shl3",    0, 1, 0, 3'd2, 8'h00, 0, 0, 4'd0, 8'h08, 0, 4'd0, 1);
        step("cnt_shl4",    0, 1, 0, 3'd2, 8'h00, 0, 0, 4'd0, 8'h10, 0, 4'd0, 0);
        step("load_5a",     0, 1, 0, 3'd1, 8'h5A, 0, 1, 4'd2, 8'h5A, 0, 4'd2, 0);
        step("clr_shl",     0, 1, 1, 3'd2, 8'h00, 1, 0, 4'd0, 8'h00, 0, 4'd2, 0);
        step("reload_5a",   0, 1, 0, 3'd1, 8'h5A, 0, 0, 4'd0, 8'h5A, 0, 4'd2, 0);
        step("en_low",      0, 0, 0, 3'd1, 8'h00, 0, 0, 4'd0, 8'h5A, 0, 4'd2, 0);
        step("mode7",       0, 1, 0, 3'd7, 8'h00, 1, 0, 4'd0, 8'h5A, 0, 4'd2, 0);
        step("hold",        0, 1, 0, 3'd0, 8'h00, 1, 0, 4'd0, 8'h5A, 0, 4'd2, 0);
        step("ld_shl_9",    0, 1, 0, 3'd2, 8'h00, 1, 1, 4'd9, 8'hB5, 0, 4'd9, 0);
        step("ld_cnt1",     0, 0, 0, 3'd0, 8'h00, 0, 1, 4'd1, 8'hB5, 0, 4'd1, 0);
        step("ld_over_done",0, 1, 0, 3'd2, 8'h00, 0, 1, 4'd5, 8'h6A, 1, 4'd5, 0);
        step("ld_cnt2",     0, 0, 0, 3'd0, 8'h00, 0, 1, 4'd2, 8'h6A, 1, 4'd2, 0);
        step("rst_mid",     1, 1, 0, 3'd3, 8'h00, 1, 0, 4'd0, 8'h00, 0, 4'd0, 0);
        step("post_rst1",   0, 1, 0, 3'd3, 8'h00, 1, 0, 4'd0, 8'h80, 0, 4'd0, 0);
        step("post_rst2",   0, 1, 0, 3'd3, 8'h00, 1, 0, 4'd0, 8'hC0, 0, 4'd0, 0);
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        total++;
        if (exp_q.size() == 0) passed++;
        else $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
